// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared defaults and FSM state type for the writeback arbiter
//
// Purpose: parameter defaults and the starvation FSM state encoding shared by
//          regfile_wb_arbiter and wb_scoreboard.
// Contents: DEF_ADDRESS_WIDTH, DEF_DATA_WIDTH, DEF_STARVE_LIMIT, arb_state_t.
package regfile_wb_arbiter_pkg;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STARVING = 2'd1,
        ST_FORCE    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - pending-destination scoreboard for long-latency ops
//
// Purpose: one pending bit per architectural register. Set on issue, cleared on
//          accepted long-unit writeback; set wins on a same-address collision.
//          Bit 0 is tied low so register 0 never appears pending.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_set_valid/i_set_addr   mark a destination pending (visible next cycle)
//   i_clr_valid/i_clr_addr   clear a destination
//   i_rd_addr_a/i_rd_addr_b  read addresses
//   o_rd_pend_a/o_rd_pend_b  pending state of the read addresses
//   o_pending                full bitmask
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_set_valid,
    input  logic [ADDRESS_WIDTH-1:0]    i_set_addr,
    input  logic                        i_clr_valid,
    input  logic [ADDRESS_WIDTH-1:0]    i_clr_addr,
    input  logic [ADDRESS_WIDTH-1:0]    i_rd_addr_a,
    input  logic [ADDRESS_WIDTH-1:0]    i_rd_addr_b,
    output logic                        o_rd_pend_a,
    output logic                        o_rd_pend_b,
    output logic [2**ADDRESS_WIDTH-1:0] o_pending
);

    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam logic [NREG-1:0] ZERO_MASK = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_valid) w_set_mask[i_set_addr] = 1'b1;
        if (i_clr_valid) w_clr_mask[i_clr_addr] = 1'b1;
    end

    // Clear first, then OR in the set so a colliding set survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ZERO_MASK;
        end
    end

    assign o_pending   = r_pending;
    assign o_rd_pend_a = r_pending[i_rd_addr_a];
    assign o_rd_pend_b = r_pending[i_rd_addr_b];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with starvation control
//
// Purpose: arbitrates the single register-file write port between the pipeline
//          writeback (no backpressure) and a long-latency unit (valid/ready).
//          A starvation FSM forces a long-unit grant after STARVE_LIMIT waiting
//          cycles; a pipeline write colliding with a forced grant is parked in a
//          one-entry hold buffer and written the following cycle.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   p_valid/p_addr/p_data          pipeline writeback
//   l_valid/l_addr/l_data/l_ready  long-unit writeback handshake
//   iss_valid/iss_addr             long op issue, marks destination pending
//   A1, A2                         decode source addresses
//   stall                          decode hold
//   WE3/A3/WD3                     registered register-file write port
//   pending                        scoreboard bitmask
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        p_valid,
    input  logic [ADDRESS_WIDTH-1:0]    p_addr,
    input  logic [DATA_WIDTH-1:0]       p_data,
    input  logic                        l_valid,
    input  logic [ADDRESS_WIDTH-1:0]    l_addr,
    input  logic [DATA_WIDTH-1:0]       l_data,
    output logic                        l_ready,
    input  logic                        iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]    iss_addr,
    input  logic [ADDRESS_WIDTH-1:0]    A1,
    input  logic [ADDRESS_WIDTH-1:0]    A2,
    output logic                        stall,
    output logic                        WE3,
    output logic [ADDRESS_WIDTH-1:0]    A3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic [2**ADDRESS_WIDTH-1:0] pending
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t               r_state;
    logic [CNT_W-1:0]         r_cnt;

    logic                     r_hold_valid;
    logic [ADDRESS_WIDTH-1:0] r_hold_addr;
    logic [DATA_WIDTH-1:0]    r_hold_data;

    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_a3;
    logic [DATA_WIDTH-1:0]    r_wd3;

    logic                     w_l_ready;
    logic                     w_l_accept;
    logic                     w_grant_valid;
    logic [ADDRESS_WIDTH-1:0] w_grant_addr;
    logic [DATA_WIDTH-1:0]    w_grant_data;
    logic                     w_hold_load;
    logic                     w_hold_next_valid;
    logic                     w_pend_a;
    logic                     w_pend_b;

    assign w_l_ready  = (r_state == ST_FORCE) || (!r_hold_valid && !p_valid);
    assign w_l_accept = l_valid && w_l_ready;

    // Grant order: hold buffer, forced long write, pipeline, long write.
    always_comb begin
        w_grant_valid     = 1'b0;
        w_grant_addr      = '0;
        w_grant_data      = '0;
        w_hold_load       = 1'b0;
        w_hold_next_valid = r_hold_valid;
        if (r_hold_valid) begin
            w_grant_valid     = 1'b1;
            w_grant_addr      = r_hold_addr;
            w_grant_data      = r_hold_data;
            // An in-flight pipeline write arriving while draining refills the slot.
            w_hold_load       = p_valid;
            w_hold_next_valid = p_valid;
        end else if ((r_state == ST_FORCE) && l_valid) begin
            w_grant_valid     = 1'b1;
            w_grant_addr      = l_addr;
            w_grant_data      = l_data;
            w_hold_load       = p_valid;
            w_hold_next_valid = p_valid;
        end else if (p_valid) begin
            w_grant_valid     = 1'b1;
            w_grant_addr      = p_addr;
            w_grant_data      = p_data;
        end else if (l_valid) begin
            w_grant_valid     = 1'b1;
            w_grant_addr      = l_addr;
            w_grant_data      = l_data;
        end
    end

    // Write port and hold buffer. Address-0 grants are consumed with WE3 low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_a3         <= '0;
            r_wd3        <= '0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
        end else begin
            r_we         <= w_grant_valid && (w_grant_addr != '0);
            if (w_grant_valid) begin
                r_a3  <= w_grant_addr;
                r_wd3 <= w_grant_data;
            end
            r_hold_valid <= w_hold_next_valid;
            if (w_hold_load) begin
                r_hold_addr <= p_addr;
                r_hold_data <= p_data;
            end
        end
    end

    // Starvation FSM. FORCE lasts one cycle: the long write is taken if still
    // offered, and a withdrawn request simply returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (l_valid && !w_l_ready) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= (CNT_ONE >= CNT_LIMIT) ? ST_FORCE : ST_STARVING;
                    end
                end
                ST_STARVING: begin
                    if (!l_valid || w_l_ready) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if ((r_cnt + CNT_ONE) >= CNT_LIMIT) r_state <= ST_FORCE;
                    end
                end
                ST_FORCE: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    wb_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (iss_valid && (iss_addr != '0)),
        .i_set_addr  (iss_addr),
        .i_clr_valid (w_l_accept),
        .i_clr_addr  (l_addr),
        .i_rd_addr_a (A1),
        .i_rd_addr_b (A2),
        .o_rd_pend_a (w_pend_a),
        .o_rd_pend_b (w_pend_b),
        .o_pending   (pending)
    );

    assign stall = (r_state == ST_FORCE) || r_hold_valid
                 || ((A1 != '0) && w_pend_a) || ((A2 != '0) && w_pend_b);

    assign l_ready = w_l_ready;
    assign WE3     = r_we;
    assign A3      = r_a3;
    assign WD3     = r_wd3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_valid = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic        l_valid = 1'b0;
    logic [4:0]  l_addr = '0;
    logic [31:0] l_data = '0;
    logic        l_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [4:0]  A1 = '0;
    logic [4:0]  A2 = '0;
    logic        stall;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] pending;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .l_valid   (l_valid),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .l_ready   (l_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .A1        (A1),
        .A2        (A2),
        .stall     (stall),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Write-port monitor: every WE3 pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (WE3 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got A3=%0d WD3=%h, expected no write", A3, WD3);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (A3 !== e.addr || WD3 !== e.data) begin
                    errors++;
                    $display("FAIL wb_data: got A3=%0d WD3=%h, expected A3=%0d WD3=%h",
                             A3, WD3, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        p_valid   = 1'b0;
        l_valid   = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b expected 0", WE3); end
        checks++; if (A3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d expected 0", A3); end
        checks++; if (WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h expected 0", WD3); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
        rst = 1'b0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL reset_l_ready: got %b expected 1", l_ready); end
    endtask

    task automatic test_pipeline_write();
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h0000_00AA;
        exp_q.push_back('{addr: 5'd5, data: 32'h0000_00AA});
        settle();
        checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL pipe_l_ready: got %b expected 0", l_ready); end
        tick();
        p_valid = 1'b0;
        tick();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL pipe_single_pulse: got WE3=%b expected 0", WE3); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] addrs [3];
        addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd31;
        for (int i = 0; i < 3; i++) begin
            p_valid = 1'b1; p_addr = addrs[i]; p_data = $urandom;
            exp_q.push_back('{addr: p_addr, data: p_data});
            tick();
        end
        p_valid = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        p_valid = 1'b1; p_addr = 5'd10; p_data = 32'h1111_0010;
        l_valid = 1'b1; l_addr = 5'd7;  l_data = 32'h7777_0007;
        settle();
        checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL conflict_l_ready_busy: got %b expected 0", l_ready); end
        exp_q.push_back('{addr: 5'd10, data: 32'h1111_0010});
        tick();
        p_valid = 1'b0;
        settle();
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL conflict_l_ready_free: got %b expected 1", l_ready); end
        exp_q.push_back('{addr: 5'd7, data: 32'h7777_0007});
        tick();
        l_valid = 1'b0;
        tick();
    endtask

    task automatic test_force();
        logic [31:0] p4_data;
        l_valid = 1'b1; l_addr = 5'd9; l_data = 32'h9999_0009;
        for (int i = 0; i < 4; i++) begin
            p_valid = 1'b1; p_addr = 5'(11 + i); p_data = 32'hA000_0000 + 32'(i);
            exp_q.push_back('{addr: p_addr, data: p_data});
            settle();
            checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL force_wait_l_ready%0d: got %b expected 0", i, l_ready); end
            tick();
        end
        p_addr = 5'd15; p4_data = 32'hA000_0004; p_data = p4_data;
        settle();
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL force_l_ready: got %b expected 1", l_ready); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL force_stall: got %b expected 1", stall); end
        exp_q.push_back('{addr: 5'd9, data: 32'h9999_0009});
        exp_q.push_back('{addr: 5'd15, data: p4_data});
        tick();
        idle_inputs();
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b expected 1", stall); end
        checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL hold_l_ready: got %b expected 0", l_ready); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_hold_stall: got %b expected 0", stall); end
        tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        iss_valid = 1'b0; A1 = 5'd3;
        settle();
        checks++; if (pending !== 32'h0000_0008) begin errors++; $display("FAIL sb_pending_set: got %h expected 00000008", pending); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_wait%0d: got %b expected 1", i, stall); end
            tick();
        end
        l_valid = 1'b1; l_addr = 5'd3; l_data = 32'h3333_0003;
        exp_q.push_back('{addr: 5'd3, data: 32'h3333_0003});
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_accept: got %b expected 1", stall); end
        tick();
        l_valid = 1'b0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_release: got %b expected 0", stall); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL sb_pending_clear: got %h expected 0", pending); end
        A1 = 5'd0;
        // Set and clear of the same address in one cycle: set wins.
        iss_valid = 1'b1; iss_addr = 5'd4;
        l_valid = 1'b1; l_addr = 5'd4; l_data = 32'h4444_0004;
        exp_q.push_back('{addr: 5'd4, data: 32'h4444_0004});
        tick();
        idle_inputs(); A2 = 5'd4;
        settle();
        checks++; if (pending !== 32'h0000_0010) begin errors++; $display("FAIL sb_set_wins: got %h expected 00000010", pending); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_a2: got %b expected 1", stall); end
        l_valid = 1'b1; l_data = 32'h4444_0005;
        exp_q.push_back('{addr: 5'd4, data: 32'h4444_0005});
        tick();
        l_valid = 1'b0;
        settle();
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL sb_pending_clear2: got %h expected 0", pending); end
        A2 = 5'd0;
        tick();
    endtask

    task automatic test_zero();
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'h0000_00FF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick();
        idle_inputs();
        settle();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL zero_we3: got %b expected 0", WE3); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL zero_pending: got %h expected 0", pending); end
        A1 = 5'd0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", stall); end
        tick();
    endtask

    task automatic test_reset_force();
        iss_valid = 1'b1; iss_addr = 5'd20;
        tick();
        iss_valid = 1'b0;
        settle();
        checks++; if (pending !== 32'h0010_0000) begin errors++; $display("FAIL rf_pending_set: got %h expected 00100000", pending); end
        l_valid = 1'b1; l_addr = 5'd12; l_data = 32'hC0C0_000C;
        for (int i = 0; i < 4; i++) begin
            p_valid = 1'b1; p_addr = 5'(21 + i); p_data = 32'hB000_0000 + 32'(i);
            exp_q.push_back('{addr: p_addr, data: p_data});
            tick();
        end
        p_addr = 5'd25; p_data = 32'hB000_0004;
        exp_q.push_back('{addr: 5'd12, data: 32'hC0C0_000C});
        tick();
        // Hold buffer now holds the pipeline write; reset must discard it.
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL rf_we3: got %b expected 0", WE3); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rf_pending: got %h expected 0", pending); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rf_stall: got %b expected 0", stall); end
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL rf_l_ready: got %b expected 1", l_ready); end
        tick();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL rf_hold_discarded: got WE3=%b expected 0", WE3); end
    endtask

    initial begin
        test_reset();
        test_pipeline_write();
        test_back_to_back();
        test_conflict();
        test_force();
        test_scoreboard();
        test_zero();
        test_reset_force();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max cycles a pending long-unit write waits before forced grant.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 p_valid, p_addr, p_data  input  1/ADDRESS_WIDTH/DATA_WIDTH  pipeline writeback; no backpressure.
REQ-007 l_valid, l_addr, l_data  input  1/ADDRESS_WIDTH/DATA_WIDTH  long-latency unit writeback request.
REQ-008 l_ready  output  1  long-unit write accepted this cycle when l_valid && l_ready.
REQ-009 iss_valid, iss_addr  input  1/ADDRESS_WIDTH  long-latency op issued; marks destination pending.
REQ-010 A1, A2  input  ADDRESS_WIDTH each  decode-stage source addresses.
REQ-011 stall  output  1  decode must hold.
REQ-012 WE3, A3, WD3  output  1/ADDRESS_WIDTH/DATA_WIDTH  registered register-file write port.
REQ-013 pending  output  2**ADDRESS_WIDTH  scoreboard bitmask.

Function
REQ-014 Write port SHALL be registered: request granted in cycle N appears on WE3/A3/WD3 in cycle N+1, for exactly one cycle.
REQ-015 Grant priority SHALL be: hold buffer > long unit in FORCE > pipeline > long unit.
REQ-016 l_ready SHALL be combinational: high when FSM in FORCE, or when no hold-buffer entry and p_valid low.
REQ-017 Granted writes to address 0 SHALL be consumed but produce WE3=0.
REQ-018 FSM states IDLE, STARVING, FORCE; starve counter width clog2(STARVE_LIMIT+1).
REQ-019 IDLE->STARVING when l_valid && !l_ready; counter loads 1.
REQ-020 STARVING: counter increments each cycle l_valid && !l_ready; ->FORCE when counter reaches STARVE_LIMIT; ->IDLE on l accept or l_valid low.
REQ-021 FORCE: l granted unconditionally; ->IDLE on l accept (same cycle); counter cleared.
REQ-022 In FORCE with p_valid high, pipeline write SHALL be captured in a one-entry hold buffer and written the next cycle; WD3/A3 unchanged from captured values.
REQ-023 stall SHALL be high in FORCE, while hold buffer occupied, or when (A1!=0 && pending[A1]) || (A2!=0 && pending[A2]).
REQ-024 Hold buffer SHALL never overflow: stall in FORCE guarantees at most one p_valid captured.
REQ-025 pending[iss_addr] SHALL set on iss_valid (iss_addr!=0), visible next cycle.
REQ-026 pending[l_addr] SHALL clear on accepted long write.
REQ-027 Simultaneous set and clear of same address: set wins.
REQ-028 pending[0] SHALL always read 0.
REQ-029 p_valid writes SHALL not modify pending.

Reset
REQ-030 On rst: WE3=0, A3=0, WD3=0, pending=0, hold buffer empty, FSM=IDLE, counter=0.
REQ-031 rst mid-operation SHALL discard hold buffer and any ungranted request; output WE3=0 next cycle.
REQ-032 After rst deasserts, l_ready reflects REQ-016 in the first cycle.

Structure
REQ-033 Shared package SHALL hold FSM state enum, STARVE_LIMIT default, ADDRESS_WIDTH/DATA_WIDTH defaults.
REQ-034 Scoreboard SHALL be one sub-module, wb_scoreboard (set/clear/read ports, pending output).
REQ-035 WE3/A3/WD3 SHALL connect directly to the register-file write port.

Verification
REQ-036 p_valid addr 5 data 0xAA -> next cycle WE3=1, A3=5, WD3=0xAA.
REQ-037 p_valid and l_valid (addr 7) same cycle -> l_ready=0; p written; l written first cycle p_valid low.
REQ-038 p_valid high continuously, l_valid addr 9 -> FORCE after 4 waiting cycles; stall=1; l written; p of that cycle written from hold buffer next cycle.
REQ-039 iss_valid addr 3, then A1=3 -> stall=1 until l write addr 3 accepted; stall=0 the cycle after.
REQ-040 p_valid addr 0 data 0xFF -> WE3=0; iss_valid addr 0 -> pending stays 0.
REQ-041 rst during FORCE with hold buffer full -> next cycle WE3=0, pending=0, FSM IDLE, stall=0.
